// File: rtl/can_reg_pkg.sv
// Shared definitions for the CAN register access arbiter.
//   arb_state_t   : access sequencer states
//   req_id_t      : requester identity (host bus or CAN protocol core)
//   DEF_PROT_MASK : registers that accept writes only in reset mode
package can_reg_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_DONE   = 2'd2
  } arb_state_t;

  typedef enum logic {
    REQ_HOST = 1'b0,
    REQ_CORE = 1'b1
  } req_id_t;

  localparam logic [31:0] DEF_PROT_MASK = 32'h0000_00FE;

endpackage

// File: rtl/can_rr_arb2.sv
// Two-way round-robin arbiter between the host bus and the CAN core.
// Ports:
//   clk, rst_n         : clock, asynchronous active-low reset
//   host_req, core_req : request levels
//   take               : a grant is consumed this cycle (sequencer idle)
//   gnt_vld            : at least one requester is asking
//   gnt_id             : requester that wins if a grant is taken now
module can_rr_arb2
  import can_reg_pkg::*;
(
  input  logic    clk,
  input  logic    rst_n,
  input  logic    host_req,
  input  logic    core_req,
  input  logic    take,
  output logic    gnt_vld,
  output req_id_t gnt_id
);

  req_id_t last_grant;

  always_comb begin
    gnt_vld = host_req | core_req;
    gnt_id  = REQ_HOST;
    if (host_req && core_req) begin
      gnt_id = (last_grant == REQ_CORE) ? REQ_HOST : REQ_CORE;
    end else if (core_req) begin
      gnt_id = REQ_CORE;
    end
  end

  // Reset to CORE so the host wins the first tie.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant <= REQ_CORE;
    end else if (take && gnt_vld) begin
      last_grant <= gnt_id;
    end
  end

endmodule

// File: rtl/can_reg_access_arb.sv
// Arbitrates host bus and CAN core access to the CAN register bank.
// Each access runs IDLE -> ACCESS -> DONE; all outputs are registered, so
// the write strobe, protection error, read data and ack all become visible
// on the edge that closes ACCESS (the bank captures on the following edge).
// Ports:
//   clk, rst_n                          : clock, async active-low reset
//   host_req/wr/addr/wdata, host_ack/rdata : host 4-phase access port
//   core_req/wr/addr/wdata, core_ack/rdata : CAN core 4-phase access port
//   reset_mode                          : enables writes to protected regs
//   reg_q                               : flattened bank contents
//   reg_we, reg_wdata                   : one-hot write strobe and data
//   wr_prot_err                         : pulse when a write is rejected
module can_reg_access_arb
  import can_reg_pkg::*;
#(
  parameter int              ADDR_W    = 5,
  parameter int              DATA_W    = 8,
  parameter int              NREG      = 32,
  parameter logic [NREG-1:0] PROT_MASK = DEF_PROT_MASK[NREG-1:0],
  parameter int              U_DLY     = 1
)(
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   host_req,
  input  logic                   host_wr,
  input  logic [ADDR_W-1:0]      host_addr,
  input  logic [DATA_W-1:0]      host_wdata,
  output logic                   host_ack,
  output logic [DATA_W-1:0]      host_rdata,
  input  logic                   core_req,
  input  logic                   core_wr,
  input  logic [ADDR_W-1:0]      core_addr,
  input  logic [DATA_W-1:0]      core_wdata,
  output logic                   core_ack,
  output logic [DATA_W-1:0]      core_rdata,
  input  logic                   reset_mode,
  input  logic [NREG*DATA_W-1:0] reg_q,
  output logic [NREG-1:0]        reg_we,
  output logic [DATA_W-1:0]      reg_wdata,
  output logic                   wr_prot_err
);

  // U_DLY only shaped delayed assignments in the behavioural model; this
  // synthesizable version has no delays.
  logic unused_u_dly;
  assign unused_u_dly = ^U_DLY;

  arb_state_t        state, state_nxt;
  logic              gnt_vld;
  req_id_t           gnt_id, gnt_lat;
  logic              wr_lat;
  logic [ADDR_W-1:0] addr_lat;
  logic [DATA_W-1:0] wdata_lat;
  logic              gnt_req;
  logic              addr_hit, addr_prot, wr_ok;
  logic [NREG-1:0]   we_onehot;
  logic [DATA_W-1:0] rd_val;

  logic              host_ack_nxt, core_ack_nxt, wr_prot_err_nxt;
  logic [DATA_W-1:0] host_rdata_nxt, core_rdata_nxt, reg_wdata_nxt;
  logic [NREG-1:0]   reg_we_nxt;

  can_rr_arb2 u_arb (
    .clk      (clk),
    .rst_n    (rst_n),
    .host_req (host_req),
    .core_req (core_req),
    .take     (state == ST_IDLE),
    .gnt_vld  (gnt_vld),
    .gnt_id   (gnt_id)
  );

  // Request capture: the granted requester's command is held for the access.
  always_ff @(posedge clk) begin
    if (state == ST_IDLE && gnt_vld) begin
      gnt_lat <= gnt_id;
      if (gnt_id == REQ_HOST) begin
        wr_lat    <= host_wr;
        addr_lat  <= host_addr;
        wdata_lat <= host_wdata;
      end else begin
        wr_lat    <= core_wr;
        addr_lat  <= core_addr;
        wdata_lat <= core_wdata;
      end
    end
  end

  // Address decode: out-of-range addresses match no register, so they read
  // as zero and fail the write check.
  always_comb begin
    addr_hit  = 1'b0;
    addr_prot = 1'b0;
    we_onehot = '0;
    rd_val    = '0;
    for (int i = 0; i < NREG; i++) begin
      if (addr_lat == ADDR_W'(i)) begin
        addr_hit     = 1'b1;
        addr_prot    = PROT_MASK[i];
        we_onehot[i] = 1'b1;
        rd_val       = reg_q[i*DATA_W +: DATA_W];
      end
    end
  end

  // reset_mode is taken as it stands during ACCESS, not at request time.
  assign wr_ok   = addr_hit && (!addr_prot || reset_mode);
  assign gnt_req = (gnt_lat == REQ_HOST) ? host_req : core_req;

  always_comb begin
    state_nxt       = state;
    host_ack_nxt    = host_ack;
    core_ack_nxt    = core_ack;
    host_rdata_nxt  = host_rdata;
    core_rdata_nxt  = core_rdata;
    reg_wdata_nxt   = reg_wdata;
    reg_we_nxt      = '0;
    wr_prot_err_nxt = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (gnt_vld) state_nxt = ST_ACCESS;
      end
      ST_ACCESS: begin
        state_nxt = ST_DONE;
        if (gnt_lat == REQ_HOST) host_ack_nxt = 1'b1;
        else                     core_ack_nxt = 1'b1;
        if (wr_lat) begin
          if (wr_ok) begin
            reg_we_nxt    = we_onehot;
            reg_wdata_nxt = wdata_lat;
          end else begin
            wr_prot_err_nxt = 1'b1;
          end
        end else if (gnt_lat == REQ_HOST) begin
          host_rdata_nxt = rd_val;
        end else begin
          core_rdata_nxt = rd_val;
        end
      end
      ST_DONE: begin
        if (!gnt_req) begin
          state_nxt    = ST_IDLE;
          host_ack_nxt = 1'b0;
          core_ack_nxt = 1'b0;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Output and state registers: reset clears any strobe mid-access.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      host_ack    <= 1'b0;
      core_ack    <= 1'b0;
      host_rdata  <= '0;
      core_rdata  <= '0;
      reg_we      <= '0;
      reg_wdata   <= '0;
      wr_prot_err <= 1'b0;
    end else begin
      state       <= state_nxt;
      host_ack    <= host_ack_nxt;
      core_ack    <= core_ack_nxt;
      host_rdata  <= host_rdata_nxt;
      core_rdata  <= core_rdata_nxt;
      reg_we      <= reg_we_nxt;
      reg_wdata   <= reg_wdata_nxt;
      wr_prot_err <= wr_prot_err_nxt;
    end
  end

endmodule
